// File: rtl/tag_ram_nway_if.sv
// tag_ram_nway_if: lookup, fill and invalidate request bus plus lookup result bus for tag_ram_nway.
interface tag_ram_nway_if #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 13,
  parameter int WAYS = 2
);
  localparam int WWIDTH = (WAYS > 2) ? $clog2(WAYS) : 1;
  logic lookup_valid;
  logic [AWIDTH-1:0] lookup_index;
  logic [TWIDTH-1:0] lookup_tag;
  logic fill_valid;
  logic [AWIDTH-1:0] fill_index;
  logic [WWIDTH-1:0] fill_way;
  logic [TWIDTH-1:0] fill_tag;
  logic inval_valid;
  logic [AWIDTH-1:0] inval_index;
  logic [WWIDTH-1:0] inval_way;
  logic busy;
  logic hit_valid;
  logic hit;
  logic [WWIDTH-1:0] hit_way;
  logic [WWIDTH-1:0] victim_way;
  modport master (
    output lookup_valid, lookup_index, lookup_tag,
    output fill_valid, fill_index, fill_way, fill_tag,
    output inval_valid, inval_index, inval_way,
    input busy, hit_valid, hit, hit_way, victim_way
  );
  modport slave (
    input lookup_valid, lookup_index, lookup_tag,
    input fill_valid, fill_index, fill_way, fill_tag,
    input inval_valid, inval_index, inval_way,
    output busy, hit_valid, hit, hit_way, victim_way
  );
endinterface

// File: rtl/tag_ram_nway.sv
// tag_ram_nway: N-way tag store with reset sweep, 1-cycle registered lookup and round-robin victim.
// Define TAG_RAM_BYPASS_EN to forward same-edge fill/inval results into a lookup of the same set.
module tag_ram_nway #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 13,
  parameter int WAYS = 2
) (
  input logic clock,
  input logic reset_n,
  tag_ram_nway_if.slave bus
);
  localparam int DEPTH = 1 << AWIDTH;
  localparam int WWIDTH = (WAYS > 2) ? $clog2(WAYS) : 1;
  typedef enum logic {INIT, READY} state_t;
  state_t state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  logic hit_valid_q, hit_valid_d;
  logic [TWIDTH:0] mem [WAYS][DEPTH];
  logic [WWIDTH-1:0] rr_q [DEPTH];
  logic [WWIDTH-1:0] rr_d [DEPTH];
  logic [TWIDTH:0] rd_q [WAYS];
  logic [TWIDTH:0] rd_d [WAYS];
  logic [TWIDTH-1:0] tag_q, tag_d;
  logic [WWIDTH-1:0] rrp_q, rrp_d;
  logic ready, do_lookup, do_fill, do_inval;
  logic hit;
  logic [WWIDTH-1:0] hit_way, victim_way;
  assign ready = state_q == READY;
  assign do_lookup = ready && bus.lookup_valid;
  assign do_fill = ready && bus.fill_valid;
  assign do_inval = ready && bus.inval_valid;
  assign state_d = (state_q == INIT && cnt_q == AWIDTH'(DEPTH - 1)) ? READY : state_q;
  assign cnt_d = ready ? cnt_q : cnt_q + 1'b1;
  assign busy_d = state_d == INIT;
  assign hit_valid_d = do_lookup;
  assign tag_d = do_lookup ? bus.lookup_tag : tag_q;
  always_comb begin
    rr_d = rr_q;
    if (do_fill) rr_d[bus.fill_index] = bus.fill_way + 1'b1;
`ifdef TAG_RAM_BYPASS_EN
    rrp_d = do_lookup ? rr_d[bus.lookup_index] : rrp_q;
`else
    rrp_d = do_lookup ? rr_q[bus.lookup_index] : rrp_q;
`endif
    for (int w = 0; w < WAYS; w++) begin
      rd_d[w] = do_lookup ? mem[w][bus.lookup_index] : rd_q[w];
`ifdef TAG_RAM_BYPASS_EN
      if (do_lookup && do_inval && bus.inval_index == bus.lookup_index && bus.inval_way == WWIDTH'(w)) rd_d[w] = '0;
      if (do_lookup && do_fill && bus.fill_index == bus.lookup_index && bus.fill_way == WWIDTH'(w)) rd_d[w] = {1'b1, bus.fill_tag};
`endif
    end
  end
  // Descending scan so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    victim_way = rrp_q;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (rd_q[w][TWIDTH] && rd_q[w][TWIDTH-1:0] == tag_q) begin
        hit = 1'b1;
        hit_way = WWIDTH'(w);
      end
      if (!rd_q[w][TWIDTH]) victim_way = WWIDTH'(w);
    end
  end
  // Fill is written last so it overrides an invalidate of the same entry.
  always_ff @(posedge clock) begin
    for (int w = 0; w < WAYS; w++) begin
      if (!ready) mem[w][cnt_q] <= '0;
      if (do_inval && bus.inval_way == WWIDTH'(w)) mem[w][bus.inval_index] <= '0;
      if (do_fill && bus.fill_way == WWIDTH'(w)) mem[w][bus.fill_index] <= {1'b1, bus.fill_tag};
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q <= '0;
      busy_q <= 1'b1;
      hit_valid_q <= 1'b0;
      rr_q <= '{default: '0};
      rd_q <= '{default: '0};
      tag_q <= '0;
      rrp_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      hit_valid_q <= hit_valid_d;
      rr_q <= rr_d;
      rd_q <= rd_d;
      tag_q <= tag_d;
      rrp_q <= rrp_d;
    end
  end
  assign bus.busy = busy_q;
  assign bus.hit_valid = hit_valid_q;
  assign bus.hit = hit;
  assign bus.hit_way = hit_way;
  assign bus.victim_way = victim_way;
endmodule

// File: doc/tag_ram_nway.md
# tag_ram_nway

Parametrised N-way tag store for the set-associative cache: one tag plus valid bit per way per set, and a registered lookup with one cycle of latency. The lookup returns hit, hit way and a replacement victim. It succeeds the single-port sync-read tag RAM, which the 2-way cache currently instantiates once per way. After reset it clears its own valid bits with a sweep state machine, then serves lookups from the cache controller and fill/invalidate writes from the refill and snoop paths.

## Interface
- AWIDTH, 3: set-index width; DEPTH = 1 << AWIDTH sets.
- TWIDTH, 13: tag width.
- WAYS, 2: associativity, power of two, 2 to 8; WWIDTH = log2(WAYS) is a localparam with a minimum of 1.
- clock  in  1  rising-edge clock for all state.
- reset_n  in  1  asynchronous, active-low reset.
- lookup_valid  in  1  lookup request this cycle.
- lookup_index  in  AWIDTH  set to look up.
- lookup_tag  in  TWIDTH  tag to compare.
- fill_valid  in  1  write a tag into a way; sets valid.
- fill_index  in  AWIDTH  set to fill.
- fill_way  in  WWIDTH  way to fill; normally the last victim_way.
- fill_tag  in  TWIDTH  tag to write.
- inval_valid  in  1  clear the valid bit of one way.
- inval_index  in  AWIDTH  set to invalidate.
- inval_way  in  WWIDTH  way to invalidate.
- busy  out  1  init sweep in progress; all requests are ignored.
- hit_valid  out  1  result strobe, one cycle.
- hit  out  1  some valid way matched lookup_tag.
- hit_way  out  WWIDTH  matching way; the lowest index if several match.
- victim_way  out  WWIDTH  the lowest-index invalid way, or the set's round-robin pointer if all ways are valid.

## Operation
- Storage: WAYS arrays of DEPTH x (TWIDTH+1) with no reset (valid bit in the MSB), plus one round-robin pointer of WWIDTH bits per set in flops that reset asynchronously to 0.
- FSM states are INIT and READY.
- Reset drives the FSM to INIT with the sweep counter at 0.
- INIT: each cycle, write valid=0 to every way of set[counter], then increment the counter. At counter == DEPTH-1 the FSM moves to READY. busy = 1 while in INIT.
- READY: accepts lookup, fill and inval in any combination in the same cycle.
- Lookup: on the accepting edge, read all ways of lookup_index into registers, along with lookup_tag. Compare is combinational from those registers. hit_valid is asserted for exactly the next cycle.
- Fill: write {1, fill_tag} to way fill_way of fill_index. The pointer of fill_index becomes fill_way+1, wrapping modulo WAYS.
- Inval: write valid=0 to way inval_way of inval_index. The tag bits are don't-care.
- Fill and inval to the same set and same way in the same cycle: fill wins. Different ways in the same set: both take effect.
- A lookup in the same cycle as a write to the same set returns pre-write contents, unless the bypass feature is compiled in (see Configuration).
- hit=0 forces hit_way=0.

## Timing
- Reset values: busy=1, hit_valid=0, hit=0, hit_way=0, victim_way=0.
- INIT lasts exactly DEPTH cycles after reset_n deasserts. busy falls after the edge that clears set DEPTH-1.
- Lookup latency is 1: request at edge k, results valid in cycle k+1. Back-to-back lookups give a result every cycle.
- Requests while busy=1 are dropped, with no side effects and no hit_valid.
- A fill at edge k is visible to a lookup accepted at edge k+1.
- Reset asserted mid-operation, including mid-INIT, aborts everything. The sweep restarts from set 0 and all pointers return to 0.

## Configuration
- TAG_RAM_BYPASS_EN defined: a lookup accepted on the same edge as a fill or inval to the same set sees the written value. This applies to the tag/valid used for the compare and to the updated pointer used for victim_way. Fill-over-inval priority is preserved.
- TAG_RAM_BYPASS_EN undefined: a same-edge lookup sees the old contents. The controller must stall one cycle after a write to the same set.

## Test plan
- Reset, then idle with AWIDTH=3 -> busy=1 for exactly 8 cycles, then 0. Lookup of index 5 with tag 0x0AA -> hit=0, victim_way=0.
- Fill index 2, way 1, tag 0x123; lookup index 2, tag 0x123 one cycle later -> hit_valid=1, hit=1, hit_way=1, victim_way=0.
- Fill ways 0 and 1 of index 4 (way 0 then way 1); lookup a miss tag -> victim_way=0 (pointer wrapped). Refill way 0; lookup again -> victim_way=1.
- Fill index 6, way 0, tag 0x055; inval index 6, way 0; lookup tag 0x055 -> hit=0. Fill and inval of the same way on the same edge -> a later lookup hits.
- Fill index 1, tag 0x0F0, on the same edge as a lookup of index 1, tag 0x0F0 -> hit=0 without TAG_RAM_BYPASS_EN, hit=1 with it.
- Assert reset_n low for 1 cycle when the sweep counter is 4 -> busy stays high for a full 8 cycles after release, and every set misses afterwards.
